// File: rtl/xadc_drp_sequencer.sv
// Sweeps the enabled XADC auxiliary channels with one DRP read each per eoc trigger.
// It latches the 12-bit results per slot and flags slot timeouts and triggers that arrive while busy.
module xadc_drp_sequencer #(
    parameter logic [6:0] ADDR0       = 7'h16,
    parameter logic [6:0] ADDR1       = 7'h17,
    parameter logic [6:0] ADDR2       = 7'h1E,
    parameter logic [6:0] ADDR3       = 7'h1F,
    parameter int         TIMEOUT_CYC = 64
) (
    input  logic        CLK100MHZ,
    input  logic        rst,
    input  logic        eoc_in,
    input  logic [3:0]  ch_mask,
    input  logic        clear_err,
    output logic [6:0]  daddr_out,
    output logic        den_out,
    output logic        dwe_out,
    input  logic        drdy_in,
    input  logic [15:0] do_in,
    output logic [47:0] ch_data,
    output logic [3:0]  ch_valid,
    output logic        sweep_done,
    output logic        busy,
    output logic        timeout_err,
    output logic        overrun
);

    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  mask_q, mask_d;
    logic [1:0]  idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [6:0]  daddr_q, daddr_d;
    logic [47:0] data_q, data_d;
    logic [3:0]  valid_q, valid_d;
    logic        terr_q, terr_d;
    logic        ovr_q, ovr_d;

    function automatic logic [6:0] addr_of(input logic [1:0] idx);
        logic [6:0] a;
        case (idx)
            2'd0:    a = ADDR0;
            2'd1:    a = ADDR1;
            2'd2:    a = ADDR2;
            default: a = ADDR3;
        endcase
        return a;
    endfunction

    // Returns {found, index} of the lowest set mask bit at or above position lo.
    function automatic logic [2:0] first_from(input logic [3:0] m, input logic [2:0] lo);
        logic [2:0] r;
        r = '0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i] && (i >= int'(lo))) r = {1'b1, 2'(i)};
        end
        return r;
    endfunction

    always_comb begin
        logic [2:0] sel;
        logic       advance;
        logic       timeout_set;
        state_d     = state_q;
        mask_d      = mask_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        daddr_d     = daddr_q;
        data_d      = data_q;
        valid_d     = valid_q;
        sel         = '0;
        advance     = 1'b0;
        timeout_set = 1'b0;

        case (state_q)
            IDLE: begin
                if (eoc_in && (ch_mask != 4'd0)) begin
                    sel     = first_from(ch_mask, 3'd0);
                    mask_d  = ch_mask;
                    idx_d   = sel[1:0];
                    daddr_d = addr_of(sel[1:0]);
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (drdy_in) begin
                    data_d[int'(idx_q)*12 +: 12] = do_in[15:4];
                    valid_d[idx_q]               = 1'b1;
                    advance                      = 1'b1;
                end else if (cnt_q == CNT_MAX) begin
                    timeout_set = 1'b1;
                    advance     = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (advance) begin
                    sel = first_from(mask_q, {1'b0, idx_q} + 3'd1);
                    if (sel[2]) begin
                        idx_d   = sel[1:0];
                        daddr_d = addr_of(sel[1:0]);
                        state_d = ISSUE;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A new error event beats a simultaneous clear.
        terr_d = clear_err ? 1'b0 : terr_q;
        if (timeout_set) terr_d = 1'b1;
        ovr_d = clear_err ? 1'b0 : ovr_q;
        if (eoc_in && (state_q != IDLE)) ovr_d = 1'b1;
    end

    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            state_q <= IDLE;
            mask_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            daddr_q <= '0;
            data_q  <= '0;
            valid_q <= '0;
            terr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            daddr_q <= daddr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            terr_q  <= terr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign den_out     = (state_q == ISSUE);
    assign dwe_out     = 1'b0;
    assign daddr_out   = daddr_q;
    assign busy        = (state_q != IDLE);
    assign sweep_done  = (state_q == DONE);
    assign ch_data     = data_q;
    assign ch_valid    = valid_q;
    assign timeout_err = terr_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_xadc_drp_sequencer.sv
// Randomized bench for xadc_drp_sequencer: a behavioural DRP responder and slot model
// predict addresses, captured data, valid bits, error flags and timeout spacing.
module tb_xadc_drp_sequencer;

    logic        CLK100MHZ = 1'b0;
    logic        rst, eoc_in, clear_err, drdy_in;
    logic [3:0]  ch_mask;
    logic [15:0] do_in;
    logic [6:0]  daddr_out;
    logic        den_out, dwe_out, sweep_done, busy, timeout_err, overrun;
    logic [47:0] ch_data;
    logic [3:0]  ch_valid;

    int checks = 0;
    int errors = 0;

    logic [11:0] modelData [4];
    logic [3:0]  modelValid;
    bit          expTerr, expOvr;

    xadc_drp_sequencer dut (
        .CLK100MHZ   (CLK100MHZ),
        .rst         (rst),
        .eoc_in      (eoc_in),
        .ch_mask     (ch_mask),
        .clear_err   (clear_err),
        .daddr_out   (daddr_out),
        .den_out     (den_out),
        .dwe_out     (dwe_out),
        .drdy_in     (drdy_in),
        .do_in       (do_in),
        .ch_data     (ch_data),
        .ch_valid    (ch_valid),
        .sweep_done  (sweep_done),
        .busy        (busy),
        .timeout_err (timeout_err),
        .overrun     (overrun)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    function automatic logic [47:0] packModel();
        return {modelData[3], modelData[2], modelData[1], modelData[0]};
    endfunction

    function automatic logic [6:0] slotAddr(input int s);
        logic [6:0] a;
        case (s)
            0:       a = 7'h16;
            1:       a = 7'h17;
            2:       a = 7'h1E;
            default: a = 7'h1F;
        endcase
        return a;
    endfunction

    task automatic modelReset();
        for (int s = 0; s < 4; s++) modelData[s] = 12'h000;
        modelValid = 4'h0;
        expTerr    = 1'b0;
        expOvr     = 1'b0;
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, "_chData"},  ch_data,     packModel());
        checkOutput({tag, "_chValid"}, ch_valid,    modelValid);
        checkOutput({tag, "_tErr"},    timeout_err, expTerr);
        checkOutput({tag, "_ovr"},     overrun,     expOvr);
        checkOutput({tag, "_busy"},    busy,        1'b0);
        checkOutput({tag, "_den"},     den_out,     1'b0);
        checkOutput({tag, "_dwe"},     dwe_out,     1'b0);
    endtask

    // One full sweep: slots in 'answer' get drdy after a delay, the rest are left to time out.
    task automatic applyStimulus(input logic [3:0] mask, input logic [3:0] answer,
                                 input bit fixedData, input bit injectEoc);
        logic [6:0]  expAddr [$];
        int          expSlot [$];
        logic [15:0] fixedVals [4];
        logic [15:0] dval;
        int countdown, curSlot, denSeen, cycle, lastEvent;
        bit finished, injectNext, injected, lastDrdy, curAnswered;
        fixedVals[0] = 16'hA5F0;
        fixedVals[1] = 16'h1230;
        fixedVals[2] = 16'hFFF0;
        fixedVals[3] = 16'h0000;
        for (int s = 0; s < 4; s++) begin
            if (mask[s]) begin
                expAddr.push_back(slotAddr(s));
                expSlot.push_back(s);
            end
        end
        if ((mask & ~answer) != 4'h0) expTerr = 1'b1;
        countdown = -1; curSlot = 0; denSeen = 0; cycle = 0; lastEvent = 0;
        finished = 0; injectNext = 0; injected = 0; lastDrdy = 0; curAnswered = 1;

        @(negedge CLK100MHZ);
        eoc_in  = 1'b1;
        ch_mask = mask;
        @(negedge CLK100MHZ);
        checkOutput("denLatency", den_out, 1'b1);
        ch_mask = 4'($urandom);
        while (!finished && cycle < 400) begin
            drdy_in = 1'b0;
            eoc_in  = 1'b0;
            do_in   = 16'($urandom);
            if (injectNext) begin
                eoc_in     = 1'b1;
                expOvr     = 1'b1;
                injectNext = 0;
            end
            if (lastDrdy) checkOutput("dataNextCycle", ch_data, packModel());
            lastDrdy = 0;
            if (countdown > 0) begin
                countdown--;
                if (countdown == 0) begin
                    dval    = fixedData ? fixedVals[curSlot] : 16'($urandom);
                    drdy_in = 1'b1;
                    do_in   = dval;
                    modelData[curSlot]  = dval[15:4];
                    modelValid[curSlot] = 1'b1;
                    countdown = -1;
                    lastDrdy  = 1;
                end
            end
            if (den_out || sweep_done) begin
                if (!curAnswered) checkOutput("timeoutGap", cycle - lastEvent, 65);
                lastEvent = cycle;
            end
            if (den_out) begin
                denSeen++;
                checkOutput("busyInSweep", busy, 1'b1);
                if (expAddr.size() == 0) begin
                    checkOutput("extraDen", 1'b1, 1'b0);
                end else begin
                    checkOutput("denAddr", daddr_out, expAddr.pop_front());
                    curSlot     = expSlot.pop_front();
                    curAnswered = answer[curSlot];
                    countdown   = curAnswered ? (fixedData ? 3 : int'($urandom_range(1, 5))) : -1;
                end
                if (injectEoc && !injected) begin
                    injected   = 1;
                    injectNext = 1;
                end
            end
            if (sweep_done) finished = 1;
            @(negedge CLK100MHZ);
            cycle++;
        end
        drdy_in = 1'b0;
        eoc_in  = 1'b0;
        checkOutput("sweepDone", finished, 1'b1);
        checkOutput("denCount", denSeen, $countones(mask));
        checkOutput("doneOnce", sweep_done, 1'b0);
        checkAll("sweep");
    endtask

    initial begin
        rst = 1'b1; eoc_in = 1'b0; clear_err = 1'b0; drdy_in = 1'b0;
        ch_mask = 4'h0; do_in = 16'h0;
        modelReset();
        repeat (3) @(negedge CLK100MHZ);
        checkOutput("rstAddr", daddr_out, 7'h00);
        checkAll("reset");
        rst = 1'b0;
        @(negedge CLK100MHZ);

        applyStimulus(4'b1111, 4'b1111, 1'b1, 1'b0);
        checkOutput("fixedData", ch_data, {12'h000, 12'hFFF, 12'h123, 12'hA5F});
        applyStimulus(4'b0100, 4'b0100, 1'b0, 1'b0);
        applyStimulus(4'b0011, 4'b0010, 1'b0, 1'b1);
        checkOutput("timeoutFlag", timeout_err, 1'b1);

        @(negedge CLK100MHZ);
        clear_err = 1'b1;
        expTerr = 1'b0; expOvr = 1'b0;
        @(negedge CLK100MHZ);
        clear_err = 1'b0;
        checkAll("clearErr");

        for (int n = 0; n < 12; n++) begin
            logic [3:0] m, a;
            m = 4'($urandom_range(1, 15));
            a = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            applyStimulus(m, a, 1'b0, 1'($urandom));
        end

        // Zero mask: no DRP activity at all.
        @(negedge CLK100MHZ);
        eoc_in = 1'b1; ch_mask = 4'h0;
        @(negedge CLK100MHZ);
        eoc_in = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (den_out || busy) checkOutput("mask0Activity", {den_out, busy}, 2'b00);
            @(negedge CLK100MHZ);
        end
        checkAll("mask0");

        // Spurious drdy while idle must not touch the slot data.
        drdy_in = 1'b1; do_in = 16'hBEEF;
        @(negedge CLK100MHZ);
        drdy_in = 1'b0;
        @(negedge CLK100MHZ);
        checkAll("idleDrdy");

        // Reset in WAIT followed by a late drdy.
        eoc_in = 1'b1; ch_mask = 4'b0011;
        @(negedge CLK100MHZ);
        eoc_in = 1'b0;
        @(negedge CLK100MHZ);
        checkOutput("preRstBusy", busy, 1'b1);
        rst = 1'b1;
        @(negedge CLK100MHZ);
        rst = 1'b0;
        modelReset();
        drdy_in = 1'b1; do_in = 16'h7770;
        @(negedge CLK100MHZ);
        drdy_in = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (den_out) checkOutput("denAfterRst", den_out, 1'b0);
            @(negedge CLK100MHZ);
        end
        checkOutput("rstMidAddr", daddr_out, 7'h00);
        checkAll("rstMid");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
